// File: rtl/transform_scheduler.sv
// Per-frame sequencer: walks the instance table, loads each transform
// and streams that model's triangles into the model-to-world transformer.
package transform_scheduler_pkg;
  typedef logic [191:0] transform_t;
  typedef logic [143:0] triangle_t;
endpackage

module transform_scheduler
  import transform_scheduler_pkg::*;
#(
  parameter int INST_W       = 6,
  parameter int TRI_ADDR_W   = 12,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [INST_W:0]       num_instances,
  output logic                  busy,
  output logic                  done,
  output logic                  inst_rd_en,
  output logic [INST_W-1:0]     inst_addr,
  input  transform_t            inst_transform,
  input  logic [TRI_ADDR_W-1:0] inst_tri_base,
  input  logic [TRI_ADDR_W-1:0] inst_tri_count,
  output logic                  tri_rd_en,
  output logic [TRI_ADDR_W-1:0] tri_addr,
  input  triangle_t             tri_rd_data,
  output transform_t            xf_transform,
  output triangle_t             xf_triangle,
  output logic                  xf_valid,
  input  logic                  xf_ready,
  input  logic                  xf_busy,
  output logic [15:0]           tri_issued
);

  localparam int RW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [INST_W:0]       IDX_ONE = 1;
  localparam logic [TRI_ADDR_W-1:0] TRI_ONE = 1;
  localparam logic [RW-1:0]         RUN_ONE = 1;
  localparam logic [RW-1:0]         RUN_END = RW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, NEXT_INST, INST_WAIT, TRI_RD,
    TRI_WAIT, ISSUE, DRAIN, FINISH
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic [INST_W:0]         n_inst;
  logic [INST_W:0]         idx;
  logic [TRI_ADDR_W-1:0]   ptr;
  logic [TRI_ADDR_W-1:0]   cnt;
  logic [RW-1:0]           run;

  logic start_ok;
  logic ld_inst;
  logic ld_tri;
  logic accept;
  logic in_drain;

  assign start_ok = (state == IDLE) && start;
  assign ld_inst  = (state == INST_WAIT);
  assign ld_tri   = (state == TRI_WAIT);
  assign accept   = (state == ISSUE) && xf_ready;
  assign in_drain = (state == DRAIN);

  assign busy       = (state != IDLE) && (state != FINISH);
  assign done       = (state == FINISH);
  assign inst_rd_en = (state == NEXT_INST) && (idx != n_inst);
  assign inst_addr  = idx[INST_W-1:0];
  assign tri_rd_en  = (state == TRI_RD);
  assign tri_addr   = ptr;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (start) state_n = NEXT_INST;
      NEXT_INST: state_n = (idx == n_inst) ? FINISH : INST_WAIT;
      INST_WAIT: state_n = (inst_tri_count == '0) ? NEXT_INST : TRI_RD;
      TRI_RD:    state_n = TRI_WAIT;
      TRI_WAIT:  state_n = ISSUE;
      ISSUE:     if (xf_ready) state_n = (cnt == TRI_ONE) ? DRAIN : TRI_RD;
      // Transform may only change once the pipeline has been idle long enough
      DRAIN:     if (!xf_busy && run == RUN_END) state_n = NEXT_INST;
      FINISH:    state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      n_inst       <= '0;
      idx          <= '0;
      ptr          <= '0;
      cnt          <= '0;
      run          <= '0;
      xf_transform <= '0;
      xf_triangle  <= '0;
      xf_valid     <= 1'b0;
      tri_issued   <= '0;
    end else begin
      state <= state_n;
      unique case (1'b1)
        start_ok: begin
          n_inst     <= num_instances;
          idx        <= '0;
          tri_issued <= '0;
        end
        ld_inst: begin
          xf_transform <= inst_transform;
          ptr          <= inst_tri_base;
          cnt          <= inst_tri_count;
          if (inst_tri_count == '0) idx <= idx + IDX_ONE;
        end
        ld_tri: begin
          xf_triangle <= tri_rd_data;
          xf_valid    <= 1'b1;
        end
        accept: begin
          xf_valid <= 1'b0;
          ptr      <= ptr + TRI_ONE;
          cnt      <= cnt - TRI_ONE;
          run      <= '0;
          if (tri_issued != 16'hFFFF) tri_issued <= tri_issued + 16'd1;
          if (cnt == TRI_ONE) idx <= idx + IDX_ONE;
        end
        in_drain: run <= xf_busy ? '0 : run + RUN_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_transform_scheduler.sv
// Directed bench for transform_scheduler with memory, ready and
// busy models driven from small hand-built instance tables.
module tb_transform_scheduler;
  import transform_scheduler_pkg::*;

  localparam int INST_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [INST_W:0]   num_instances = '0;
  logic              busy, done, inst_rd_en, tri_rd_en;
  logic [INST_W-1:0] inst_addr;
  transform_t        inst_transform = '0;
  logic [11:0]       inst_tri_base = '0;
  logic [11:0]       inst_tri_count = '0;
  logic [11:0]       tri_addr;
  triangle_t         tri_rd_data = '0;
  transform_t        xf_transform;
  triangle_t         xf_triangle;
  logic              xf_valid;
  logic              xf_ready = 1'b1;
  logic              xf_busy;
  logic [15:0]       tri_issued;

  int errors = 0;
  int checks = 0;

  logic [11:0] tbl_base [8];
  logic [11:0] tbl_cnt  [8];
  int          bcnt = 0;

  logic [11:0]       rd_q [$];
  logic [INST_W-1:0] ia_q [$];
  triangle_t         acc_q [$];
  transform_t        accx_q [$];
  int                dones = 0;
  int                acc_cnt = 0;
  int                stall_left = 0;
  int                lowrun = 0;
  int                sw_cnt = 0;
  logic              stall_on = 1'b0;
  logic              ready_def = 1'b1;
  logic              chk_xf = 1'b0;
  logic [11:0]       stall_addr = '0;
  transform_t        prev_xf = '0;

  transform_scheduler dut (
    .clk(clk), .rst(rst), .start(start),
    .num_instances(num_instances),
    .busy(busy), .done(done),
    .inst_rd_en(inst_rd_en), .inst_addr(inst_addr),
    .inst_transform(inst_transform),
    .inst_tri_base(inst_tri_base),
    .inst_tri_count(inst_tri_count),
    .tri_rd_en(tri_rd_en), .tri_addr(tri_addr),
    .tri_rd_data(tri_rd_data),
    .xf_transform(xf_transform),
    .xf_triangle(xf_triangle),
    .xf_valid(xf_valid), .xf_ready(xf_ready),
    .xf_busy(xf_busy), .tri_issued(tri_issued)
  );

  always #5 clk = ~clk;

  function automatic transform_t tx(input int i);
    return {6{32'hA5A5_0000 + 32'(i)}};
  endfunction

  function automatic triangle_t tw(input logic [11:0] a);
    return {9{4'hC, a}};
  endfunction

  task automatic chk(input string tag, input logic [191:0] got,
                     input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  assign xf_busy = (bcnt != 0);

  // Registered memories and a transformer that stays busy 3 cycles per triangle
  always @(posedge clk) begin
    if (inst_rd_en) begin
      inst_transform <= tx(int'(inst_addr));
      inst_tri_base  <= tbl_base[inst_addr[2:0]];
      inst_tri_count <= tbl_cnt[inst_addr[2:0]];
    end
    if (tri_rd_en) tri_rd_data <= tw(tri_addr);
    if (xf_valid && xf_ready) bcnt <= 3;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end

  always @(negedge clk) begin
    if (tri_rd_en) rd_q.push_back(tri_addr);
    if (inst_rd_en) ia_q.push_back(inst_addr);
    if (done) dones++;
    if (stall_left > 0 && (stall_on || (xf_valid && acc_cnt == 1))) begin
      stall_on = 1'b1;
      xf_ready = 1'b0;
      stall_left--;
      chk("stall_valid", xf_valid, 1);
      chk("stall_tri", xf_triangle, tw(stall_addr));
      chk("stall_rd", tri_rd_en, 0);
    end else begin
      stall_on = 1'b0;
      xf_ready = ready_def;
    end
    if (rst && xf_valid && xf_ready) begin
      acc_q.push_back(xf_triangle);
      accx_q.push_back(xf_transform);
      acc_cnt++;
    end
    if (chk_xf && xf_transform !== prev_xf) begin
      sw_cnt++;
      chk("xf_drain", lowrun >= 2, 1);
      chk("xf_sw_valid", xf_valid, 0);
    end
    prev_xf = xf_transform;
    lowrun  = xf_busy ? 0 : lowrun + 1;
  end

  task automatic clear_log();
    rd_q.delete();
    ia_q.delete();
    acc_q.delete();
    accx_q.delete();
    dones   = 0;
    acc_cnt = 0;
  endtask

  task automatic go(input int n);
    clear_log();
    @(negedge clk);
    num_instances = 7'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl_base[i] = '0;
      tbl_cnt[i]  = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", xf_valid, 0);
    chk("rst_inst_rd", inst_rd_en, 0);
    chk("rst_tri_rd", tri_rd_en, 0);
    chk("rst_issued", tri_issued, 0);
    chk("rst_inst_addr", inst_addr, 0);
    chk("rst_tri_addr", tri_addr, 0);
    chk("rst_xf", xf_transform, 0);
    chk("rst_tri", xf_triangle, 0);
    rst = 1'b1;
    @(negedge clk);

    tbl_base[0] = 12'h010;
    tbl_cnt[0]  = 12'd3;
    go(1);
    wait_done();
    chk("t1_nrd", rd_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_addr", rd_q[k], 12'h010 + 12'(k));
      chk("t1_tri", acc_q[k], tw(12'h010 + 12'(k)));
      chk("t1_xf", accx_q[k], tx(0));
    end
    chk("t1_issued", tri_issued, 3);
    chk("t1_dones", dones, 1);
    chk("t1_xf_end", xf_transform, tx(0));
    chk("t1_ninst", ia_q.size(), 1);

    stall_left = 5;
    stall_addr = 12'h011;
    go(1);
    wait_done();
    chk("t2_stalled", stall_left, 0);
    chk("t2_nrd", rd_q.size(), 3);
    chk("t2_nacc", acc_cnt, 3);
    chk("t2_tri1", acc_q[1], tw(12'h011));
    chk("t2_issued", tri_issued, 3);

    tbl_base[0] = 12'h100; tbl_cnt[0] = 12'd2;
    tbl_base[1] = 12'h200; tbl_cnt[1] = 12'd0;
    tbl_base[2] = 12'h300; tbl_cnt[2] = 12'd1;
    chk_xf = 1'b1;
    sw_cnt = 0;
    go(3);
    wait_done();
    chk_xf = 1'b0;
    chk("t3_sw", sw_cnt, 2);
    chk("t3_ninst", ia_q.size(), 3);
    for (int k = 0; k < 3; k++) chk("t3_iaddr", ia_q[k], k);
    chk("t3_nrd", rd_q.size(), 3);
    chk("t3_a0", rd_q[0], 12'h100);
    chk("t3_a1", rd_q[1], 12'h101);
    chk("t3_a2", rd_q[2], 12'h300);
    chk("t3_x0", accx_q[0], tx(0));
    chk("t3_x1", accx_q[1], tx(0));
    chk("t3_x2", accx_q[2], tx(2));
    chk("t3_issued", tri_issued, 3);
    chk("t3_xf_end", xf_transform, tx(2));

    tbl_base[0] = 12'hFFF;
    tbl_cnt[0]  = 12'd2;
    go(1);
    wait_done();
    chk("t4_nrd", rd_q.size(), 2);
    chk("t4_a0", rd_q[0], 12'hFFF);
    chk("t4_a1", rd_q[1], 12'h000);
    chk("t4_tri0", acc_q[0], tw(12'hFFF));
    chk("t4_tri1", acc_q[1], tw(12'h000));
    chk("t4_issued", tri_issued, 2);

    clear_log();
    @(negedge clk);
    num_instances = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_done_c1", done, 0);
    chk("t5_busy_c1", busy, 1);
    @(negedge clk);
    chk("t5_done_c2", done, 1);
    chk("t5_busy_c2", busy, 0);
    @(negedge clk);
    chk("t5_done_c3", done, 0);
    chk("t5_reads", rd_q.size() + ia_q.size(), 0);
    chk("t5_issued", tri_issued, 0);

    tbl_base[0] = 12'h020;
    tbl_cnt[0]  = 12'd3;
    go(1);
    for (int i = 0; i < 200 && acc_cnt < 1; i++) @(negedge clk);
    num_instances = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("t5b_issued", tri_issued, 3);
    chk("t5b_dones", dones, 1);
    chk("t5b_nrd", rd_q.size(), 3);
    chk("t5b_idle", busy, 0);

    ready_def   = 1'b0;
    tbl_base[0] = 12'h030;
    tbl_cnt[0]  = 12'd3;
    go(1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (xf_valid) seen = 1'b1;
      end
      chk("t6_issue", seen, 1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_valid", xf_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_issued", tri_issued, 0);
    chk("t6_tri", xf_triangle, 0);
    @(negedge clk);
    rst = 1'b1;
    ready_def = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_nodone", dones, 0);
    tbl_base[0] = 12'h040;
    tbl_cnt[0]  = 12'd1;
    go(1);
    wait_done();
    chk("t6_iaddr", ia_q[0], 0);
    chk("t6_a0", rd_q[0], 12'h040);
    chk("t6_tri0", acc_q[0], tw(12'h040));
    chk("t6_issued2", tri_issued, 1);
    chk("t6_dones", dones, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
